// File: rtl/if_req_pkg.sv
// Shared constants and types for the instruction-fetch request stage.
// Holds the reset PC, fetch-group geometry, state encoding and redirect bundle.
package if_req_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC          = 32'h1C00_0000;
  localparam logic [XLEN-1:0] FETCH_GROUP_BYTES = 32'd8;

  localparam logic [0:0] ST_REQ  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  typedef struct packed {
    logic            excep;
    logic [XLEN-1:0] excep_pc;
    logic            branch;
    logic [XLEN-1:0] branch_pc;
  } redirect_t;

  // Start of the next fetch group; wraps naturally at 2^32.
  function automatic logic [XLEN-1:0] next_group_pc(input logic [XLEN-1:0] pc);
    return (pc & ~(FETCH_GROUP_BYTES - 32'd1)) + FETCH_GROUP_BYTES;
  endfunction

endpackage

// File: rtl/if_req_npc.sv
// Next fetch-PC selection: exception redirect, branch redirect, sequential or hold.
// Purely combinational; the registers live in if_req_stage.
module if_req_npc
  import if_req_pkg::*;
(
  input  redirect_t       redirect_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  input  logic            advance_i,
  output logic            flush_o,
  output logic [XLEN-1:0] npc_o
);

  assign flush_o = redirect_i.excep | redirect_i.branch;

  always_comb begin
    npc_o = fetch_pc_i;
    if (redirect_i.excep) begin
      npc_o = redirect_i.excep_pc;
    end else if (redirect_i.branch) begin
      npc_o = redirect_i.branch_pc;
    end else if (advance_i) begin
      npc_o = next_group_pc(fetch_pc_i);
    end
  end

endmodule

// File: rtl/if_req_stage.sv
// Instruction-fetch request stage: issues cache requests at fetch_pc and hands
// accepted two-slot fetch groups to the response stage, holding one when it stalls.
module if_req_stage
  import if_req_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            excep_flush_i,
  input  logic [XLEN-1:0] excep_pc_i,
  input  logic            branch_flush_i,
  input  logic [XLEN-1:0] branch_pc_i,
  input  logic            next_allowin_i,
  output logic            inst_sram_req_o,
  output logic [XLEN-1:0] inst_sram_addr_o,
  input  logic            inst_sram_addr_ok_i,
  output logic            line1_to_next_valid_o,
  output logic            line2_to_next_valid_o,
  output logic [XLEN-1:0] to_next_pc_o,
  output logic            now_clk_inst_ram_req_o,
  output logic            inst_req_cancel_o
);

  logic [0:0]      st_q, st_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] held_pc_q, held_pc_d;
  logic            in_req, in_hold, accept, flush, slot_valid;
  logic [XLEN-1:0] slot_pc;
  redirect_t       redirect;

  // Gating with rst_n keeps every handshake output quiet while reset is held.
  assign in_req  = rst_n && (st_q == ST_REQ);
  assign in_hold = rst_n && (st_q == ST_HOLD);
  assign accept  = in_req && inst_sram_addr_ok_i;

  assign redirect = '{excep:     excep_flush_i,
                      excep_pc:  excep_pc_i,
                      branch:    branch_flush_i,
                      branch_pc: branch_pc_i};

  if_req_npc u_npc (
    .redirect_i (redirect),
    .fetch_pc_i (fetch_pc_q),
    .advance_i  (accept),
    .flush_o    (flush),
    .npc_o      (fetch_pc_d)
  );

  assign inst_sram_req_o  = in_req;
  assign inst_sram_addr_o = fetch_pc_q;

  assign slot_valid = !flush && (in_hold || (accept && next_allowin_i));
  assign slot_pc    = in_hold ? held_pc_q : fetch_pc_q;

  assign line1_to_next_valid_o  = slot_valid;
  assign line2_to_next_valid_o  = slot_valid && !slot_pc[2];
  assign to_next_pc_o           = slot_pc;
  assign now_clk_inst_ram_req_o = slot_valid && next_allowin_i;
  assign inst_req_cancel_o      = flush && (accept || in_hold);

  always_comb begin
    st_d      = st_q;
    held_pc_d = held_pc_q;
    if (flush) begin
      st_d = ST_REQ;
    end else if (in_hold) begin
      if (next_allowin_i) st_d = ST_REQ;
    end else if (accept && !next_allowin_i) begin
      st_d      = ST_HOLD;
      held_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ST_REQ;
      fetch_pc_q <= RESET_PC;
      held_pc_q  <= '0;
    end else begin
      st_q       <= st_d;
      fetch_pc_q <= fetch_pc_d;
      held_pc_q  <= held_pc_d;
    end
  end

endmodule

// File: tb/tb_if_req_stage.sv
// Self-checking bench for if_req_stage: directed redirect/stall/wrap scenarios
// plus a randomized run against a pending-group reference model.
module tb_if_req_stage;

  logic        clk;
  logic        rst_n;
  logic        excep_flush_i;
  logic [31:0] excep_pc_i;
  logic        branch_flush_i;
  logic [31:0] branch_pc_i;
  logic        next_allowin_i;
  logic        inst_sram_req_o;
  logic [31:0] inst_sram_addr_o;
  logic        inst_sram_addr_ok_i;
  logic        line1_to_next_valid_o;
  logic        line2_to_next_valid_o;
  logic [31:0] to_next_pc_o;
  logic        now_clk_inst_ram_req_o;
  logic        inst_req_cancel_o;

  int checks = 0;
  int fails  = 0;

  if_req_stage dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .excep_flush_i          (excep_flush_i),
    .excep_pc_i             (excep_pc_i),
    .branch_flush_i         (branch_flush_i),
    .branch_pc_i            (branch_pc_i),
    .next_allowin_i         (next_allowin_i),
    .inst_sram_req_o        (inst_sram_req_o),
    .inst_sram_addr_o       (inst_sram_addr_o),
    .inst_sram_addr_ok_i    (inst_sram_addr_ok_i),
    .line1_to_next_valid_o  (line1_to_next_valid_o),
    .line2_to_next_valid_o  (line2_to_next_valid_o),
    .to_next_pc_o           (to_next_pc_o),
    .now_clk_inst_ram_req_o (now_clk_inst_ram_req_o),
    .inst_req_cancel_o      (inst_req_cancel_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs just after a rising edge and wait to the falling edge.
  task automatic drv(input logic ef, input logic [31:0] epc, input logic bf,
                     input logic [31:0] bpc, input logic allow, input logic ack);
    excep_flush_i       = ef;
    excep_pc_i          = epc;
    branch_flush_i      = bf;
    branch_pc_i         = bpc;
    next_allowin_i      = allow;
    inst_sram_addr_ok_i = ack;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    adv();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drv(1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b1, 1'b1);
    checks++; if (inst_sram_req_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_req got %b want 0", inst_sram_req_o); end
    checks++; if (inst_sram_addr_o !== 32'h1C00_0000) begin fails++; $display("[TB] FAIL reset_addr got %h want 1c000000", inst_sram_addr_o); end
    checks++; if ({line1_to_next_valid_o, line2_to_next_valid_o, now_clk_inst_ram_req_o, inst_req_cancel_o} !== 4'b0000) begin
      fails++; $display("[TB] FAIL reset_outs got %b%b%b%b want 0000", line1_to_next_valid_o, line2_to_next_valid_o, now_clk_inst_ram_req_o, inst_req_cancel_o);
    end
    adv();
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
      checks++; if (inst_sram_req_o !== 1'b1) begin fails++; $display("[TB] FAIL seq_req[%0d] got %b want 1", i, inst_sram_req_o); end
      checks++; if (inst_sram_addr_o !== 32'h1C00_0000 + 32'(8 * i)) begin
        fails++; $display("[TB] FAIL seq_addr[%0d] got %h want %h", i, inst_sram_addr_o, 32'h1C00_0000 + 32'(8 * i));
      end
      checks++; if ({line1_to_next_valid_o, line2_to_next_valid_o, now_clk_inst_ram_req_o} !== 3'b111) begin
        fails++; $display("[TB] FAIL seq_valid[%0d] got %b%b%b want 111", i, line1_to_next_valid_o, line2_to_next_valid_o, now_clk_inst_ram_req_o);
      end
      adv();
    end
  endtask

  task automatic test_branch_no_ack();
    drv(1'b0, 32'h0, 1'b1, 32'h1C00_0104, 1'b1, 1'b0);
    checks++; if (inst_req_cancel_o !== 1'b0) begin fails++; $display("[TB] FAIL br_noack_cancel got %b want 0", inst_req_cancel_o); end
    checks++; if (line1_to_next_valid_o !== 1'b0) begin fails++; $display("[TB] FAIL br_noack_valid got %b want 0", line1_to_next_valid_o); end
    adv();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    checks++; if (inst_sram_addr_o !== 32'h1C00_0104) begin fails++; $display("[TB] FAIL br_target_addr got %h want 1c000104", inst_sram_addr_o); end
    checks++; if ({line1_to_next_valid_o, line2_to_next_valid_o} !== 2'b10) begin
      fails++; $display("[TB] FAIL br_slots got %b%b want 10", line1_to_next_valid_o, line2_to_next_valid_o);
    end
    checks++; if (to_next_pc_o !== 32'h1C00_0104) begin fails++; $display("[TB] FAIL br_to_next_pc got %h want 1c000104", to_next_pc_o); end
    adv();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (inst_sram_addr_o !== 32'h1C00_0108) begin fails++; $display("[TB] FAIL br_seq_addr got %h want 1c000108", inst_sram_addr_o); end
    adv();
  endtask

  task automatic test_hold();
    drv(1'b0, 32'h0, 1'b1, 32'h1C00_0020, 1'b1, 1'b0);
    adv();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (line1_to_next_valid_o !== 1'b0) begin fails++; $display("[TB] FAIL hold_entry_valid got %b want 0", line1_to_next_valid_o); end
    adv();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (inst_sram_req_o !== 1'b0) begin fails++; $display("[TB] FAIL hold_req got %b want 0", inst_sram_req_o); end
    checks++; if ({line1_to_next_valid_o, now_clk_inst_ram_req_o} !== 2'b10) begin
      fails++; $display("[TB] FAIL hold_stall got %b%b want 10", line1_to_next_valid_o, now_clk_inst_ram_req_o);
    end
    adv();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    checks++; if (to_next_pc_o !== 32'h1C00_0020) begin fails++; $display("[TB] FAIL hold_release_pc got %h want 1c000020", to_next_pc_o); end
    checks++; if ({line1_to_next_valid_o, line2_to_next_valid_o, now_clk_inst_ram_req_o} !== 3'b111) begin
      fails++; $display("[TB] FAIL hold_release_valid got %b%b%b want 111", line1_to_next_valid_o, line2_to_next_valid_o, now_clk_inst_ram_req_o);
    end
    adv();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if ({inst_sram_req_o, inst_sram_addr_o} !== {1'b1, 32'h1C00_0028}) begin
      fails++; $display("[TB] FAIL hold_next_addr got %b/%h want 1/1c000028", inst_sram_req_o, inst_sram_addr_o);
    end
    adv();
  endtask

  task automatic test_hold_flush();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    adv();
    drv(1'b1, 32'h1C00_8000, 1'b1, 32'h1C00_0400, 1'b1, 1'b0);
    checks++; if (inst_req_cancel_o !== 1'b1) begin fails++; $display("[TB] FAIL hflush_cancel got %b want 1", inst_req_cancel_o); end
    checks++; if ({line1_to_next_valid_o, line2_to_next_valid_o, now_clk_inst_ram_req_o} !== 3'b000) begin
      fails++; $display("[TB] FAIL hflush_valid got %b%b%b want 000", line1_to_next_valid_o, line2_to_next_valid_o, now_clk_inst_ram_req_o);
    end
    adv();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (inst_req_cancel_o !== 1'b0) begin fails++; $display("[TB] FAIL hflush_cancel_once got %b want 0", inst_req_cancel_o); end
    checks++; if ({inst_sram_req_o, inst_sram_addr_o} !== {1'b1, 32'h1C00_8000}) begin
      fails++; $display("[TB] FAIL hflush_addr got %b/%h want 1/1c008000", inst_sram_req_o, inst_sram_addr_o);
    end
    adv();
  endtask

  task automatic test_flush_with_ack();
    drv(1'b0, 32'h0, 1'b1, 32'h1C00_0200, 1'b1, 1'b1);
    checks++; if (inst_req_cancel_o !== 1'b1) begin fails++; $display("[TB] FAIL ackflush_cancel got %b want 1", inst_req_cancel_o); end
    checks++; if ({line1_to_next_valid_o, now_clk_inst_ram_req_o} !== 2'b00) begin
      fails++; $display("[TB] FAIL ackflush_valid got %b%b want 00", line1_to_next_valid_o, now_clk_inst_ram_req_o);
    end
    adv();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (inst_sram_addr_o !== 32'h1C00_0200) begin fails++; $display("[TB] FAIL ackflush_addr got %h want 1c000200", inst_sram_addr_o); end
    adv();
  endtask

  task automatic test_wrap();
    drv(1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0);
    adv();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    checks++; if ({line1_to_next_valid_o, line2_to_next_valid_o} !== 2'b11) begin
      fails++; $display("[TB] FAIL wrap_slots got %b%b want 11", line1_to_next_valid_o, line2_to_next_valid_o);
    end
    adv();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (inst_sram_addr_o !== 32'h0000_0000) begin fails++; $display("[TB] FAIL wrap_addr got %h want 00000000", inst_sram_addr_o); end
    adv();
  endtask

  task automatic test_reset_mid_hold();
    drv(1'b0, 32'h0, 1'b1, 32'h1C00_0300, 1'b1, 1'b0);
    adv();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    adv();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    checks++; if ({inst_sram_req_o, line1_to_next_valid_o, inst_req_cancel_o} !== 3'b000) begin
      fails++; $display("[TB] FAIL rsthold_outs got %b%b%b want 000", inst_sram_req_o, line1_to_next_valid_o, inst_req_cancel_o);
    end
    checks++; if (inst_sram_addr_o !== 32'h1C00_0000) begin fails++; $display("[TB] FAIL rsthold_addr got %h want 1c000000", inst_sram_addr_o); end
    adv();
    rst_n = 1'b1;
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if ({inst_sram_req_o, line1_to_next_valid_o} !== 2'b10) begin
      fails++; $display("[TB] FAIL rsthold_restart got %b%b want 10", inst_sram_req_o, line1_to_next_valid_o);
    end
    adv();
  endtask

  // Reference model: the next address to request, and at most one accepted
  // group waiting for the response stage to make room.
  task automatic test_random();
    logic [31:0] m_next_addr;
    logic        m_pending;
    logic [31:0] m_pending_pc;
    logic        ef, bf, allow, ack, redirect, e_valid, e_line2, e_now, e_cancel;
    logic [31:0] epc, bpc, e_pc;
    do_reset();
    m_next_addr  = 32'h1C00_0000;
    m_pending    = 1'b0;
    m_pending_pc = 32'h0;
    for (int n = 0; n < 400; n++) begin
      ef    = ($urandom_range(0, 9) == 0);
      bf    = ($urandom_range(0, 7) == 0);
      epc   = $urandom;
      bpc   = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      allow = ($urandom_range(0, 3) != 0);
      ack   = ($urandom_range(0, 2) != 0);
      drv(ef, epc, bf, bpc, allow, ack);
      redirect = ef || bf;
      if (m_pending) begin
        e_valid  = !redirect;
        e_pc     = m_pending_pc;
        e_now    = !redirect && allow;
        e_cancel = redirect;
      end else begin
        e_valid  = !redirect && ack && allow;
        e_pc     = m_next_addr;
        e_now    = e_valid;
        e_cancel = redirect && ack;
      end
      e_line2 = e_valid && (e_pc % 8 < 4);
      checks++; if (inst_sram_req_o !== !m_pending) begin fails++; $display("[TB] FAIL rnd_req[%0d] got %b want %b", n, inst_sram_req_o, !m_pending); end
      if (!m_pending) begin
        checks++; if (inst_sram_addr_o !== m_next_addr) begin fails++; $display("[TB] FAIL rnd_addr[%0d] got %h want %h", n, inst_sram_addr_o, m_next_addr); end
      end
      checks++; if ({line1_to_next_valid_o, line2_to_next_valid_o, now_clk_inst_ram_req_o, inst_req_cancel_o} !== {e_valid, e_line2, e_now, e_cancel}) begin
        fails++; $display("[TB] FAIL rnd_ctl[%0d] got %b%b%b%b want %b%b%b%b", n, line1_to_next_valid_o, line2_to_next_valid_o,
                          now_clk_inst_ram_req_o, inst_req_cancel_o, e_valid, e_line2, e_now, e_cancel);
      end
      if (e_valid) begin
        checks++; if (to_next_pc_o !== e_pc) begin fails++; $display("[TB] FAIL rnd_pc[%0d] got %h want %h", n, to_next_pc_o, e_pc); end
      end
      if (redirect) begin
        m_next_addr = ef ? epc : bpc;
        m_pending   = 1'b0;
      end else if (m_pending) begin
        if (allow) m_pending = 1'b0;
      end else if (ack) begin
        if (!allow) begin
          m_pending    = 1'b1;
          m_pending_pc = m_next_addr;
        end
        m_next_addr = 32'((64'(m_next_addr) / 8 + 1) * 8);
      end
      adv();
    end
  endtask

  initial begin
    rst_n               = 1'b0;
    excep_flush_i       = 1'b0;
    excep_pc_i          = 32'h0;
    branch_flush_i      = 1'b0;
    branch_pc_i         = 32'h0;
    next_allowin_i      = 1'b0;
    inst_sram_addr_ok_i = 1'b0;
    $display("[TB] starting if_req_stage bench");
    test_reset();
    test_sequential();
    test_branch_no_ack();
    test_hold();
    test_hold_flush();
    test_flush_with_ack();
    test_wrap();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
